// File: rtl/fifo_pkg.sv
// Sizing helpers shared by the level FIFO and its ring pointers.
package fifo_pkg;

    function automatic int cnt_width(input int capacity);
        return $clog2(capacity + 1);
    endfunction

    function automatic int ptr_width(input int capacity);
        return (capacity > 2) ? $clog2(capacity) : 1;
    endfunction

endpackage

// File: rtl/ring_ptr.sv
// Wrapping index 0..CAPACITY-1; a single-entry ring has no pointer state at all.
module ring_ptr
    import fifo_pkg::*;
#(
    parameter int CAPACITY = 4,
    localparam int PW = ptr_width(CAPACITY)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          inc,
    output logic [PW-1:0] ptr
);

    generate
        if (CAPACITY == 1) begin : g_single
            logic unused_ok;
            assign unused_ok = ^{clk, rst, clr, inc};
            assign ptr       = '0;
        end else begin : g_ring
            localparam logic [PW-1:0] LAST = PW'(CAPACITY - 1);

            logic [PW-1:0] ptr_reg;
            logic [PW-1:0] ptr_next;

            always_comb begin
                ptr_next = ptr_reg;
                if (clr) begin
                    ptr_next = '0;
                end else if (inc) begin
                    ptr_next = (ptr_reg == LAST) ? '0 : ptr_reg + 1'b1;
                end
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    ptr_reg <= '0;
                end else begin
                    ptr_reg <= ptr_next;
                end
            end

            assign ptr = ptr_reg;
        end
    endgenerate

endmodule

// File: rtl/level_fifo.sv
// Synchronous FIFO with level flags, optional first-word fall-through and
// arbitrary (non power-of-two) depth.
module level_fifo
    import fifo_pkg::*;
#(
    parameter type TYPE         = logic,
    parameter int  CAPACITY     = 4,
    parameter bit  FALL_THROUGH = 1'b0,
    parameter int  ALMOST_FULL  = CAPACITY - 1,
    parameter int  ALMOST_EMPTY = 1,
    localparam int CW = cnt_width(CAPACITY)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    input  logic          w_valid,
    output logic          w_ready,
    input  TYPE           w_data,
    output logic          r_valid,
    input  logic          r_ready,
    output TYPE           r_data,
    output logic [CW-1:0] count,
    output logic          almost_full,
    output logic          almost_empty
);

    localparam int            PW       = ptr_width(CAPACITY);
    localparam logic [CW-1:0] CNT_FULL = CW'(CAPACITY);
    localparam logic [CW-1:0] AF_LVL   = CW'(ALMOST_FULL);
    localparam logic [CW-1:0] AE_LVL   = CW'(ALMOST_EMPTY);

    generate
        if (CAPACITY < 1 || ALMOST_FULL > CAPACITY || ALMOST_EMPTY > CAPACITY) begin : g_bad_params
            $error("level_fifo: illegal CAPACITY / ALMOST_FULL / ALMOST_EMPTY combination");
        end
    endgenerate

    // Plain array without reset so it maps onto distributed RAM.
    TYPE mem [CAPACITY];

    logic [CW-1:0] count_reg;
    logic [CW-1:0] count_next;
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          is_empty;
    logic          push;
    logic          pop;
    logic          bypass;
    logic          push_store;
    logic          pop_store;

    assign is_empty = (count_reg == '0);

    // Readiness looks only at the stored count, so a same-cycle pop never
    // opens a full FIFO; reset suppresses any read handshake in its cycle.
    assign w_ready = (count_reg != CNT_FULL) && !flush;
    assign r_valid = (!is_empty || (FALL_THROUGH && w_valid)) && !flush && !rst;
    assign r_data  = (FALL_THROUGH && is_empty) ? w_data : mem[rd_ptr];

    assign push       = w_valid && w_ready;
    assign pop        = r_valid && r_ready;
    assign bypass     = FALL_THROUGH && is_empty && push && pop;
    assign push_store = push && !bypass;
    assign pop_store  = pop && !bypass;

    always_comb begin
        count_next = count_reg;
        if (flush) begin
            count_next = '0;
        end else if (push_store && !pop_store) begin
            count_next = count_reg + 1'b1;
        end else if (pop_store && !push_store) begin
            count_next = count_reg - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_reg <= '0;
        end else begin
            count_reg <= count_next;
        end
    end

    always_ff @(posedge clk) begin
        if (push_store) begin
            mem[wr_ptr] <= w_data;
        end
    end

    ring_ptr #(.CAPACITY(CAPACITY)) u_wr_ptr (
        .clk (clk),
        .rst (rst),
        .clr (flush),
        .inc (push_store),
        .ptr (wr_ptr)
    );

    ring_ptr #(.CAPACITY(CAPACITY)) u_rd_ptr (
        .clk (clk),
        .rst (rst),
        .clr (flush),
        .inc (pop_store),
        .ptr (rd_ptr)
    );

    assign count        = count_reg;
    assign almost_full  = (count_reg >= AF_LVL);
    assign almost_empty = (count_reg <= AE_LVL);

endmodule

// File: tb/tb_level_fifo.sv
// Directed bench for level_fifo: three instances (depth 5, fall-through depth 4,
// depth 1) checked against a queue model every cycle plus literal expectations.
module tb_level_fifo;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    logic [7:0] mq [3][$];

    // Instance a: CAPACITY 5, registered read
    logic a_rst, a_flush, a_wv, a_rr, a_wr, a_rv, a_af, a_ae;
    logic [7:0] a_wd, a_rd;
    logic [2:0] a_cnt;
    // Instance b: CAPACITY 4, fall-through
    logic b_rst, b_flush, b_wv, b_rr, b_wr, b_rv, b_af, b_ae;
    logic [7:0] b_wd, b_rd;
    logic [2:0] b_cnt;
    // Instance c: CAPACITY 1
    logic c_rst, c_flush, c_wv, c_rr, c_wr, c_rv, c_af, c_ae;
    logic [7:0] c_wd, c_rd;
    logic [0:0] c_cnt;

    level_fifo #(.TYPE(logic [7:0]), .CAPACITY(5), .FALL_THROUGH(1'b0),
                 .ALMOST_FULL(4), .ALMOST_EMPTY(1)) u_a (
        .clk(clk), .rst(a_rst), .flush(a_flush),
        .w_valid(a_wv), .w_ready(a_wr), .w_data(a_wd),
        .r_valid(a_rv), .r_ready(a_rr), .r_data(a_rd),
        .count(a_cnt), .almost_full(a_af), .almost_empty(a_ae)
    );

    level_fifo #(.TYPE(logic [7:0]), .CAPACITY(4), .FALL_THROUGH(1'b1),
                 .ALMOST_FULL(3), .ALMOST_EMPTY(1)) u_b (
        .clk(clk), .rst(b_rst), .flush(b_flush),
        .w_valid(b_wv), .w_ready(b_wr), .w_data(b_wd),
        .r_valid(b_rv), .r_ready(b_rr), .r_data(b_rd),
        .count(b_cnt), .almost_full(b_af), .almost_empty(b_ae)
    );

    level_fifo #(.TYPE(logic [7:0]), .CAPACITY(1), .FALL_THROUGH(1'b0),
                 .ALMOST_FULL(1), .ALMOST_EMPTY(0)) u_c (
        .clk(clk), .rst(c_rst), .flush(c_flush),
        .w_valid(c_wv), .w_ready(c_wr), .w_data(c_wd),
        .r_valid(c_rv), .r_ready(c_rr), .r_data(c_rd),
        .count(c_cnt), .almost_full(c_af), .almost_empty(c_ae)
    );

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // Queue model: outputs follow from occupancy and current inputs, then the
    // queue advances by whatever handshakes the rules say happen at the edge.
    task automatic model_cycle(input int id, input int cap, input bit ft,
                               input int af_t, input int ae_t,
                               input logic rs, input logic fl, input logic wv,
                               input logic [7:0] wd, input logic rr,
                               input logic wr_a, input logic rv_a,
                               input logic [7:0] rd_a, input int cnt_a,
                               input logic af_a, input logic ae_a);
        int n;
        bit e_wr, e_rv, do_push, do_pop;
        n    = mq[id].size();
        e_wr = (n != cap) && !fl;
        e_rv = ((n != 0) || (ft && wv)) && !fl && !rs;
        chk($sformatf("m%0d.count", id), cnt_a, n);
        chk($sformatf("m%0d.w_ready", id), int'(wr_a), int'(e_wr));
        chk($sformatf("m%0d.r_valid", id), int'(rv_a), int'(e_rv));
        chk($sformatf("m%0d.almost_full", id), int'(af_a), (n >= af_t) ? 1 : 0);
        chk($sformatf("m%0d.almost_empty", id), int'(ae_a), (n <= ae_t) ? 1 : 0);
        if (e_rv) chk($sformatf("m%0d.r_data", id), int'(rd_a), (n == 0) ? int'(wd) : int'(mq[id][0]));
        if (rs || fl) begin
            mq[id].delete();
        end else begin
            do_push = wv && e_wr;
            do_pop  = e_rv && rr;
            if (!(do_pop && n == 0)) begin
                if (do_pop) void'(mq[id].pop_front());
                if (do_push) mq[id].push_back(wd);
            end
        end
    endtask

    always @(negedge clk) begin
        model_cycle(0, 5, 1'b0, 4, 1, a_rst, a_flush, a_wv, a_wd, a_rr,
                    a_wr, a_rv, a_rd, int'(a_cnt), a_af, a_ae);
        model_cycle(1, 4, 1'b1, 3, 1, b_rst, b_flush, b_wv, b_wd, b_rr,
                    b_wr, b_rv, b_rd, int'(b_cnt), b_af, b_ae);
        model_cycle(2, 1, 1'b0, 1, 0, c_rst, c_flush, c_wv, c_wd, c_rr,
                    c_wr, c_rv, c_rd, int'(c_cnt), c_af, c_ae);
    end

    task automatic a_drive(input logic rs, input logic fl, input logic wv,
                           input logic [7:0] wd, input logic rr);
        @(posedge clk); #1;
        a_rst = rs; a_flush = fl; a_wv = wv; a_wd = wd; a_rr = rr;
        @(negedge clk);
    endtask

    task automatic b_drive(input logic rs, input logic fl, input logic wv,
                           input logic [7:0] wd, input logic rr);
        @(posedge clk); #1;
        b_rst = rs; b_flush = fl; b_wv = wv; b_wd = wd; b_rr = rr;
        @(negedge clk);
    endtask

    task automatic c_drive(input logic rs, input logic fl, input logic wv,
                           input logic [7:0] wd, input logic rr);
        @(posedge clk); #1;
        c_rst = rs; c_flush = fl; c_wv = wv; c_wd = wd; c_rr = rr;
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected end before 200000");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int pushed;
        int popped;
        a_rst = 1'b1; a_flush = 1'b0; a_wv = 1'b0; a_wd = 8'h00; a_rr = 1'b0;
        b_rst = 1'b1; b_flush = 1'b0; b_wv = 1'b0; b_wd = 8'h00; b_rr = 1'b0;
        c_rst = 1'b1; c_flush = 1'b0; c_wv = 1'b0; c_wd = 8'h00; c_rr = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        a_rst = 1'b0; b_rst = 1'b0; c_rst = 1'b0;
        @(negedge clk);

        // Reset state
        chk("a.rst_count", int'(a_cnt), 0);
        chk("a.rst_w_ready", int'(a_wr), 1);
        chk("a.rst_r_valid", int'(a_rv), 0);
        chk("a.rst_almost_empty", int'(a_ae), 1);
        chk("a.rst_almost_full", int'(a_af), 0);
        chk("b.rst_r_valid", int'(b_rv), 0);
        chk("c.rst_count", int'(c_cnt), 0);
        chk("c.rst_almost_empty", int'(c_ae), 1);
        chk("c.rst_almost_full", int'(c_af), 0);

        // Fill to capacity, then drain in order
        for (int i = 1; i <= 5; i++) begin
            a_drive(0, 0, 1, 8'(i), 0);
            chk("a.fill_count", int'(a_cnt), i - 1);
            chk("a.fill_almost_full", int'(a_af), (i - 1 >= 4) ? 1 : 0);
            chk("a.fill_w_ready", int'(a_wr), 1);
        end
        a_drive(0, 0, 0, 8'h00, 0);
        chk("a.full_count", int'(a_cnt), 5);
        chk("a.full_w_ready", int'(a_wr), 0);
        chk("a.full_almost_full", int'(a_af), 1);
        chk("a.full_almost_empty", int'(a_ae), 0);
        for (int j = 1; j <= 5; j++) begin
            a_drive(0, 0, 0, 8'h00, 1);
            chk("a.drain_r_valid", int'(a_rv), 1);
            chk("a.drain_r_data", int'(a_rd), j);
            chk("a.drain_count", int'(a_cnt), 6 - j);
        end
        a_drive(0, 0, 0, 8'h00, 0);
        chk("a.empty_count", int'(a_cnt), 0);
        chk("a.empty_r_valid", int'(a_rv), 0);

        // Full with simultaneous write and read: only the pop goes through
        for (int i = 1; i <= 5; i++) a_drive(0, 0, 1, 8'(8'h10 + i), 0);
        a_drive(0, 0, 1, 8'h16, 1);
        chk("a.fullrw_count", int'(a_cnt), 5);
        chk("a.fullrw_w_ready", int'(a_wr), 0);
        chk("a.fullrw_r_data", int'(a_rd), 8'h11);
        a_drive(0, 0, 1, 8'h16, 1);
        chk("a.both_count", int'(a_cnt), 4);
        chk("a.both_w_ready", int'(a_wr), 1);
        chk("a.both_r_data", int'(a_rd), 8'h12);
        a_drive(0, 0, 0, 8'h00, 0);
        chk("a.both_after_count", int'(a_cnt), 4);
        for (int j = 0; j < 4; j++) begin
            a_drive(0, 0, 0, 8'h00, 1);
            chk("a.drain2_r_data", int'(a_rd), 8'h13 + j);
        end

        // Twelve transfers with random stalls on both sides
        pushed = 0;
        popped = 0;
        for (int cyc = 0; cyc < 400 && popped < 12; cyc++) begin
            logic wv;
            logic rr;
            wv = (pushed < 12) && ($urandom_range(0, 3) != 0);
            rr = ($urandom_range(0, 2) != 0);
            a_drive(0, 0, wv, 8'(8'h20 + pushed), rr);
            chk("a.stall_count_le5", (int'(a_cnt) <= 5) ? 1 : 0, 1);
            if (a_wv && a_wr) pushed++;
            if (a_rv && a_rr) begin
                chk("a.stall_r_data", int'(a_rd), 8'h20 + popped);
                popped++;
            end
        end
        chk("a.stall_popped", popped, 12);
        a_drive(0, 0, 0, 8'h00, 0);

        // Flush at count 3 blocks both handshakes
        for (int i = 1; i <= 3; i++) a_drive(0, 0, 1, 8'(8'h30 + i), 0);
        a_drive(0, 1, 1, 8'h34, 1);
        chk("a.flush_count", int'(a_cnt), 3);
        chk("a.flush_w_ready", int'(a_wr), 0);
        chk("a.flush_r_valid", int'(a_rv), 0);
        a_drive(0, 0, 1, 8'h0A, 0);
        chk("a.post_flush_count", int'(a_cnt), 0);
        chk("a.post_flush_r_valid", int'(a_rv), 0);
        a_drive(0, 0, 0, 8'h00, 0);
        chk("a.after_flush_r_valid", int'(a_rv), 1);
        chk("a.after_flush_r_data", int'(a_rd), 8'h0A);
        chk("a.after_flush_count", int'(a_cnt), 1);
        a_drive(0, 0, 0, 8'h00, 1);
        a_drive(0, 0, 0, 8'h00, 0);

        // Fall-through bypass and stored reads
        b_drive(0, 0, 1, 8'h07, 1);
        chk("b.bypass_r_valid", int'(b_rv), 1);
        chk("b.bypass_r_data", int'(b_rd), 8'h07);
        chk("b.bypass_count", int'(b_cnt), 0);
        b_drive(0, 0, 0, 8'h00, 0);
        chk("b.bypass_after_count", int'(b_cnt), 0);
        chk("b.bypass_after_r_valid", int'(b_rv), 0);
        b_drive(0, 0, 1, 8'h41, 0);
        b_drive(0, 0, 1, 8'h42, 0);
        b_drive(0, 0, 0, 8'h00, 1);
        chk("b.stored_count", int'(b_cnt), 2);
        chk("b.stored_r_data", int'(b_rd), 8'h41);
        b_drive(0, 0, 1, 8'h43, 1);
        chk("b.stored2_r_data", int'(b_rd), 8'h42);
        b_drive(0, 0, 0, 8'h00, 1);
        chk("b.stored3_r_data", int'(b_rd), 8'h43);
        b_drive(0, 1, 1, 8'h55, 1);
        chk("b.flush_r_valid", int'(b_rv), 0);
        b_drive(0, 0, 0, 8'h00, 0);
        chk("b.flush_after_count", int'(b_cnt), 0);

        // Single-entry FIFO: alternate, then reset while occupied
        c_drive(0, 0, 1, 8'h51, 0);
        chk("c.push_w_ready", int'(c_wr), 1);
        c_drive(0, 0, 1, 8'h52, 1);
        chk("c.full_count", int'(c_cnt), 1);
        chk("c.full_w_ready", int'(c_wr), 0);
        chk("c.full_r_data", int'(c_rd), 8'h51);
        chk("c.full_almost_full", int'(c_af), 1);
        c_drive(0, 0, 1, 8'h52, 0);
        chk("c.refill_count", int'(c_cnt), 0);
        c_drive(0, 0, 0, 8'h00, 1);
        chk("c.pop2_r_data", int'(c_rd), 8'h52);
        c_drive(0, 0, 1, 8'h53, 0);
        c_drive(1, 0, 0, 8'h00, 1);
        chk("c.rst_cycle_count", int'(c_cnt), 1);
        chk("c.rst_cycle_r_valid", int'(c_rv), 0);
        c_drive(0, 0, 0, 8'h00, 0);
        chk("c.post_rst_count", int'(c_cnt), 0);
        chk("c.post_rst_r_valid", int'(c_rv), 0);
        chk("c.post_rst_w_ready", int'(c_wr), 1);
        chk("c.post_rst_almost_empty", int'(c_ae), 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/level_fifo.md
LEVEL_FIFO -- requirements
Module: level_fifo

Interface
REQ-001 SHALL have parameter TYPE, default logic, meaning the element type carried.
REQ-002 SHALL have parameter CAPACITY, default 4, meaning the number of entries; any integer >= 1, not restricted to powers of two.
REQ-003 SHALL have parameter FALL_THROUGH, default 0, meaning first-word fall-through when set to 1.
REQ-004 SHALL have parameter ALMOST_FULL, default CAPACITY-1, meaning the almost_full threshold.
REQ-005 SHALL have parameter ALMOST_EMPTY, default 1, meaning the almost_empty threshold.
REQ-006 SHALL have clk  input  1  the single clock; all state changes on its rising edge.
REQ-007 SHALL have rst  input  1  reset, synchronous and active-high.
REQ-008 SHALL have flush  input  1  synchronous discard of all stored entries.
REQ-009 SHALL have w_valid  input  1, w_ready  output  1, and w_data  input  TYPE, forming the write handshake.
REQ-010 SHALL have r_valid  output  1, r_ready  input  1, and r_data  output  TYPE, forming the read handshake.
REQ-011 SHALL have count  output  CW  stored entry count, where CW = $clog2(CAPACITY+1).
REQ-012 SHALL have almost_full  output  1  and almost_empty  output  1  level flags.

Function
REQ-013 A push SHALL occur when w_valid && w_ready, and a pop SHALL occur when r_valid && r_ready.
REQ-014 w_ready SHALL be (count != CAPACITY) && !flush; a pop in the same cycle SHALL NOT make a full FIFO writable.
REQ-015 r_valid SHALL be ((count != 0) || (FALL_THROUGH && w_valid)) && !flush.
REQ-016 r_data SHALL be w_data when FALL_THROUGH && count == 0, and the oldest stored entry otherwise.
REQ-017 In bypass (FALL_THROUGH, count == 0, w_valid, r_ready, no flush), data SHALL pass combinationally, and count and pointers SHALL be unchanged.
REQ-018 In non-bypass operation, count SHALL update next cycle as count+1 on push only, count-1 on pop only, and unchanged on both or neither.
REQ-019 Read and write pointers SHALL wrap from CAPACITY-1 to 0.
REQ-020 Ordering SHALL be strict FIFO.
REQ-021 With FALL_THROUGH=0, read latency SHALL be 1 cycle: a word pushed in cycle N is visible at r_data in cycle N+1.
REQ-022 almost_full SHALL be (count >= ALMOST_FULL), and almost_empty SHALL be (count <= ALMOST_EMPTY).
REQ-023 Both flags SHALL be decoded from the count register only, not from the current handshake.
REQ-024 When flush=1, the next cycle SHALL have count=0 and both pointers=0, and no handshake SHALL complete in the flush cycle.
REQ-025 Simultaneous flush and rst SHALL behave as rst.
REQ-026 Storage SHALL be written only on push; stored data SHALL be unaffected by flush or rst.
REQ-027 CAPACITY=1 SHALL be supported, with no pointer state; behaviour SHALL be identical to REQ-013 to REQ-026.

Reset
REQ-028 When rst=1 at a rising edge: count=0, pointers=0, w_ready=1 (absent flush), r_valid=0 (absent fall-through write), almost_empty=1, and almost_full=(ALMOST_FULL==0).
REQ-029 Reset mid-operation SHALL discard all entries without producing any read handshake in that cycle.
REQ-030 An elaboration-time check SHALL fail when CAPACITY < 1, when ALMOST_FULL > CAPACITY, or when ALMOST_EMPTY > CAPACITY.

Structure
REQ-031 Package fifo_pkg SHALL hold a cnt_width(capacity) function returning $clog2(capacity+1) and a ptr_width(capacity) function returning max(1, $clog2(capacity)).
REQ-032 Sub-module ring_ptr (parameter CAPACITY; inputs clk, rst, clr, inc; output ptr) SHALL implement the wrapping pointer and be instantiated twice.
REQ-033 Storage SHALL be an unpacked array of TYPE with no reset, inferable as distributed RAM.

Verification (CAPACITY=5, FALL_THROUGH=0, ALMOST_FULL=4, ALMOST_EMPTY=1 unless stated)
REQ-034 Push 0x1..0x5 back-to-back with r_ready=0 -> count 1..5, w_ready=0 after 5th, almost_full high from count=4; then pop all -> 0x1..0x5 in order, count returns to 0.
REQ-035 At count=5, hold w_valid=1 and r_ready=1 -> only a pop occurs, count=4; next cycle push and pop both occur, count stays 4.
REQ-036 Run 12 push/pop pairs with random stalls -> pointers wrap twice, output sequence equals input sequence, and count never exceeds 5.
REQ-037 Assert flush at count=3 with w_valid=1 and r_ready=1 -> no handshake that cycle, count=0 next cycle, and a subsequent push of 0xA reads back as 0xA.
REQ-038 FALL_THROUGH=1, empty, w_valid=1, w_data=0x7, r_ready=1 -> r_valid=1 and r_data=0x7 in the same cycle, with count remaining 0.
REQ-039 CAPACITY=1 with alternating push and pop, and rst asserted at count=1 -> count=0 and r_valid=0 next cycle, and w_ready=1.
